// File: rtl/mips_controller.sv
// Multicycle control FSM for the 8-bit-address MIPS datapath.
// Sequences byte-wise fetch, decode, execute, memory access and writeback.
//
// Ports:
//   clk, reset (async, active-high)
//   op[5:0], funct[5:0], zero            : from datapath
//   memread, memwrite                    : byte-wide memory strobes
//   alusrca, alusrcb[1:0], alucontrol[2:0]
//   iord, irwrite[3:0], memtoreg, regdst
//   regwrite, pcen, pcsource[1:0]
//
// Optional feature macro: MIPS_CTRL_ADDI_EN adds the addi execute path.

module mips_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memread,
  output logic       memwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic       iord,
  output logic [3:0] irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       pcen,
  output logic [1:0] pcsource
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [3:0] S_FETCH1 = 4'd0;
  localparam logic [3:0] S_FETCH2 = 4'd1;
  localparam logic [3:0] S_FETCH3 = 4'd2;
  localparam logic [3:0] S_FETCH4 = 4'd3;
  localparam logic [3:0] S_DECODE = 4'd4;
  localparam logic [3:0] S_MEMADR = 4'd5;
  localparam logic [3:0] S_LBRD   = 4'd6;
  localparam logic [3:0] S_LBWR   = 4'd7;
  localparam logic [3:0] S_SBWR   = 4'd8;
  localparam logic [3:0] S_RTEX   = 4'd9;
  localparam logic [3:0] S_RTWR   = 4'd10;
  localparam logic [3:0] S_BEQEX  = 4'd11;
  localparam logic [3:0] S_JEX    = 4'd12;
  localparam logic [3:0] S_ADDIEX = 4'd13;
  localparam logic [3:0] S_ADDIWR = 4'd14;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [2:0] w_rt_alu;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH1;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH1;
    case (r_state)
      S_FETCH1: w_next = S_FETCH2;
      S_FETCH2: w_next = S_FETCH3;
      S_FETCH3: w_next = S_FETCH4;
      S_FETCH4: w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LB,
          OP_SB:    w_next = S_MEMADR;
          OP_RTYPE: w_next = S_RTEX;
          OP_BEQ:   w_next = S_BEQEX;
          OP_J:     w_next = S_JEX;
`ifdef MIPS_CTRL_ADDI_EN
          OP_ADDI:  w_next = S_ADDIEX;
`endif
          default:  w_next = S_FETCH1;
        endcase
      end
      S_MEMADR: w_next = (op == OP_LB) ? S_LBRD : S_SBWR;
      S_LBRD:   w_next = S_LBWR;
      S_RTEX:   w_next = S_RTWR;
`ifdef MIPS_CTRL_ADDI_EN
      S_ADDIEX: w_next = S_ADDIWR;
`endif
      default:  w_next = S_FETCH1;
    endcase
  end

  always_comb begin
    case (funct)
      6'b100010: w_rt_alu = 3'b110;
      6'b100100: w_rt_alu = 3'b000;
      6'b100101: w_rt_alu = 3'b001;
      6'b101010: w_rt_alu = 3'b111;
      default:   w_rt_alu = 3'b010;
    endcase
  end

  // The state register already sits at FETCH1 during reset, so the
  // outputs are forced low explicitly to keep every strobe quiet.
  always_comb begin
    memread    = 1'b0;
    memwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    alucontrol = 3'b000;
    iord       = 1'b0;
    irwrite    = 4'b0000;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    regwrite   = 1'b0;
    pcen       = 1'b0;
    pcsource   = 2'b00;
    if (!reset) begin
      case (r_state)
        S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
          memread    = 1'b1;
          alusrcb    = 2'b01;
          alucontrol = 3'b010;
          pcen       = 1'b1;
          irwrite    = 4'b0001 << r_state[1:0];
        end
        S_DECODE: begin
          alusrcb    = 2'b11;
          alucontrol = 3'b010;
        end
        S_MEMADR: begin
          alusrca    = 1'b1;
          alusrcb    = 2'b10;
          alucontrol = 3'b010;
        end
        S_LBRD: begin
          memread = 1'b1;
          iord    = 1'b1;
        end
        S_LBWR: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        S_SBWR: begin
          memwrite = 1'b1;
          iord     = 1'b1;
        end
        S_RTEX: begin
          alusrca    = 1'b1;
          alucontrol = w_rt_alu;
        end
        S_RTWR: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
        end
        S_BEQEX: begin
          alusrca    = 1'b1;
          alucontrol = 3'b110;
          pcsource   = 2'b01;
          pcen       = zero;
        end
        S_JEX: begin
          pcsource = 2'b10;
          pcen     = 1'b1;
        end
`ifdef MIPS_CTRL_ADDI_EN
        S_ADDIEX: begin
          alusrca    = 1'b1;
          alusrcb    = 2'b10;
          alucontrol = 3'b010;
        end
        S_ADDIWR: begin
          regwrite = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_controller.sv
// Self-checking bench for mips_controller.
// Reference model builds per-instruction output sequences from op rules.

module tb_mips_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memread;
  logic       memwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [2:0] alucontrol;
  logic       iord;
  logic [3:0] irwrite;
  logic       memtoreg;
  logic       regdst;
  logic       regwrite;
  logic       pcen;
  logic [1:0] pcsource;

  int n_checks;
  int n_fails;

  mips_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .memread    (memread),
    .memwrite   (memwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .alucontrol (alucontrol),
    .iord       (iord),
    .irwrite    (irwrite),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .regwrite   (regwrite),
    .pcen       (pcen),
    .pcsource   (pcsource)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [18:0] w_obs;
  assign w_obs = {memread, memwrite, alusrca, alusrcb, alucontrol,
                  iord, irwrite, memtoreg, regdst, regwrite,
                  pcen, pcsource};

  function automatic logic [18:0] ctl(
    input logic mr, input logic mw, input logic asa,
    input logic [1:0] asb, input logic [2:0] alu,
    input logic io, input logic [3:0] irw, input logic m2r,
    input logic rd, input logic rw, input logic pe,
    input logic [1:0] pcs);
    return {mr, mw, asa, asb, alu, io, irw, m2r, rd, rw, pe, pcs};
  endfunction

  function automatic bit addi_on();
`ifdef MIPS_CTRL_ADDI_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int instr_len(input logic [5:0] o);
    case (o)
      6'b100000: return 8;
      6'b101000: return 7;
      6'b000000: return 7;
      6'b000100: return 6;
      6'b000010: return 6;
      6'b001000: return addi_on() ? 7 : 5;
      default:   return 5;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic logic [18:0] expect_out(
    input logic [5:0] o, input logic [5:0] f,
    input logic z, input int step);
    logic [3:0] one;
    one = 4'b0001;
    if (step < 4)
      return ctl(1,0,0,2'b01,3'b010,0,one << step,0,0,0,1,2'b00);
    if (step == 4)
      return ctl(0,0,0,2'b11,3'b010,0,4'b0,0,0,0,0,2'b00);
    case (o)
      6'b100000, 6'b101000: begin
        if (step == 5)
          return ctl(0,0,1,2'b10,3'b010,0,4'b0,0,0,0,0,2'b00);
        if (o == 6'b100000 && step == 6)
          return ctl(1,0,0,2'b00,3'b000,1,4'b0,0,0,0,0,2'b00);
        if (o == 6'b100000)
          return ctl(0,0,0,2'b00,3'b000,0,4'b0,1,0,1,0,2'b00);
        return ctl(0,1,0,2'b00,3'b000,1,4'b0,0,0,0,0,2'b00);
      end
      6'b000000: begin
        if (step == 5)
          return ctl(0,0,1,2'b00,funct_alu(f),0,4'b0,0,0,0,0,2'b00);
        return ctl(0,0,0,2'b00,3'b000,0,4'b0,0,1,1,0,2'b00);
      end
      6'b000100:
        return ctl(0,0,1,2'b00,3'b110,0,4'b0,0,0,0,z,2'b01);
      6'b000010:
        return ctl(0,0,0,2'b00,3'b000,0,4'b0,0,0,0,1,2'b10);
      default: begin
        if (step == 5)
          return ctl(0,0,1,2'b10,3'b010,0,4'b0,0,0,0,0,2'b00);
        return ctl(0,0,0,2'b00,3'b000,0,4'b0,0,0,1,0,2'b00);
      end
    endcase
  endfunction

  // Runs the first nsteps cycles of an instruction starting in FETCH1.
  // The real opcode appears from FETCH4 on; junk before that.
  // zmode < 0 means random zero each cycle.
  task automatic run_steps(input string name, input logic [5:0] o,
                           input logic [5:0] f, input int zmode,
                           input int nsteps);
    logic [18:0] exp;
    for (int s = 0; s < nsteps; s++) begin
      if (s < 3) begin
        op    = 6'($urandom);
        funct = 6'($urandom);
      end else begin
        op    = o;
        funct = f;
      end
      zero = (zmode < 0) ? 1'($urandom) : 1'(zmode);
      #1;
      exp = expect_out(o, f, zero, s);
      n_checks++;
      if (w_obs !== exp) begin
        n_fails++;
        $display("FAIL %s op=%b step %0d: got %h expected %h",
                 name, o, s, w_obs, exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_instr(input string name, input logic [5:0] o,
                           input logic [5:0] f, input int zmode);
    run_steps(name, o, f, zmode, instr_len(o));
  endtask

  task automatic check_zero_out(input string name);
    n_checks++;
    if (w_obs !== 19'd0) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, w_obs, 19'd0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    op    = 6'd0;
    funct = 6'd0;
    zero  = 1'b0;
    #1;
    check_zero_out("reset_t0");
    @(posedge clk); #1;
    check_zero_out("reset_c1");
    @(posedge clk); #1;
    check_zero_out("reset_c2");
    reset = 1'b0;
    #1;
    run_instr("fetch_after_reset", 6'b000010, 6'd0, -1);
  endtask

  task automatic test_rtype();
    run_instr("rtype_add", 6'b000000, 6'b100000, -1);
    run_instr("rtype_sub", 6'b000000, 6'b100010, -1);
    run_instr("rtype_and", 6'b000000, 6'b100100, -1);
    run_instr("rtype_or",  6'b000000, 6'b100101, -1);
    run_instr("rtype_slt", 6'b000000, 6'b101010, -1);
    run_instr("rtype_unk", 6'b000000, 6'b000111, -1);
  endtask

  task automatic test_beq();
    run_instr("beq_taken", 6'b000100, 6'd0, 1);
    run_instr("beq_not",   6'b000100, 6'd0, 0);
  endtask

  task automatic test_lb_sb();
    run_instr("lb", 6'b100000, 6'd0, -1);
    run_instr("sb", 6'b101000, 6'd0, -1);
  endtask

  task automatic test_reset_mid();
    logic [18:0] exp;
    run_steps("mid_lb", 6'b100000, 6'd0, -1, 6);
    #1;
    exp = expect_out(6'b100000, 6'd0, zero, 6);
    n_checks++;
    if (w_obs !== exp) begin
      n_fails++;
      $display("FAIL mid_lbrd: got %h expected %h", w_obs, exp);
    end
    reset = 1'b1;
    #1;
    check_zero_out("mid_reset_now");
    @(posedge clk); #1;
    check_zero_out("mid_reset_nowb");
    reset = 1'b0;
    #1;
    run_instr("after_mid_reset", 6'b000000, 6'b100010, -1);
  endtask

  task automatic test_addi();
    run_instr("addi", 6'b001000, 6'd0, -1);
    run_instr("unknown_op", 6'b111111, 6'd0, -1);
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [6];
    logic [5:0] fns [5];
    logic [5:0] o;
    logic [5:0] f;
    ops = '{6'b000000, 6'b100000, 6'b101000,
            6'b000100, 6'b000010, 6'b001000};
    fns = '{6'b100000, 6'b100010, 6'b100100,
            6'b100101, 6'b101010};
    for (int i = 0; i < 200; i++) begin
      o = ($urandom_range(0, 4) == 0) ? 6'($urandom)
                                      : ops[$urandom_range(0, 5)];
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom)
                                      : fns[$urandom_range(0, 4)];
      run_instr("random", o, f, -1);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    test_reset();
    test_rtype();
    test_beq();
    test_lb_sb();
    test_reset_mid();
    test_addi();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
